demultiplexer4: RTL and testbench
=================================

// Module: demultiplexer4
//
// PURPOSE
// - Registered 1-to-4 stream demultiplexer. It is the steering counterpart of the
//   4-way result multiplexer: one producer stream is routed to one of four consumer
//   ports, selected per beat by a 2-bit tag.
// - Placed between the core's memory/IO request port and four targets
//   (e.g. IMEM, DMEM, MMIO, debug).
// - Built-in skid buffer sustains one beat per cycle; per-port beat counters.
//
// PARAMETERS
// - WIDTH      32  payload width in bits
// - CNT_WIDTH   8  width of each per-port delivered-beat counter
//
// PORTS
// - clock      in   1            single clock; all flops on rising edge
// - reset      in   1            synchronous, active-high
// - in_valid   in   1            producer beat valid
// - in_ready   out  1            block can accept a beat this cycle
// - in_sel     in   2            destination port (0..3) of the input beat
// - in_data    in   WIDTH        input payload
// - out_valid  out  4            bit i = beat valid on port i (at most one bit set)
// - out_ready  in   4            bit i = port i accepts this cycle
// - out_data   out  WIDTH        payload, shared by all four ports
// - count      out  4*CNT_WIDTH  slice i = beats delivered on port i
//
// BEHAVIOUR
// - Storage
//   - Main register: m_valid, m_sel, m_data.
//   - Skid register: s_valid, s_sel, s_data.
// - Handshake signals
//   - in_fire  = in_valid & in_ready
//   - out_fire = m_valid & out_ready[m_sel]
//   - in_ready = !s_valid. Driven from a flop only; no combinational path from
//     out_ready or in_valid.
//   - out_valid[i] = m_valid & (m_sel == i). Never depends on out_ready.
//   - out_data = m_data.
//   - out_ready bits of non-selected ports are ignored.
// - States (encoded by m_valid/s_valid)
//   - EMPTY(0,0)
//     - in_fire -> ONE; main <= input.
//   - ONE(1,0)
//     - in_fire & out_fire -> ONE; main <= input.
//     - in_fire only -> FULL; skid <= input.
//     - out_fire only -> EMPTY.
//     - neither -> hold.
//   - FULL(1,1)
//     - in_ready = 0.
//     - out_fire -> ONE; main <= skid.
//     - no out_fire -> hold.
//   - (0,1) is illegal; assert it never occurs.
// - Timing
//   - Latency: an accepted beat is visible on out_valid the next cycle.
//   - Throughput: 1 beat/cycle while the selected port is ready.
// - Ordering and stability
//   - Beats leave in acceptance order across all ports.
//   - A stalled destination blocks later beats to any port (head-of-line
//     blocking is intended).
//   - Once out_valid[i] rises, out_valid, m_sel and out_data stay stable until
//     out_fire.
// - Counters
//   - count[i] increments by 1 on each out_fire with m_sel == i.
//   - Wraps modulo 2^CNT_WIDTH with no saturation and no flag.
// - Reset values
//   - m_valid = s_valid = 0, so out_valid = 4'b0 and in_ready = 1.
//   - m_data = s_data = 0, so out_data = 0.
//   - m_sel = s_sel = 0.
//   - All count slices = 0.
// - Reset mid-operation
//   - Buffered beats are discarded, not delivered, and not counted.
//   - in_valid is ignored in any cycle where reset is high.
//   - Normal operation resumes on the cycle after reset deasserts.
// - No X propagation: in_sel is fully decoded; there is no default/X branch.
//
// TESTING
// - Single beat: in_sel=2, in_data=32'hDEADBEEF, out_ready=4'b1111
//   -> next cycle out_valid=4'b0100, out_data=DEADBEEF; count[2]=1 after.
// - Streaming: 8 back-to-back beats, sel 0,1,2,3,0,1,2,3, all ready
//   -> in_ready stays 1; one beat out per cycle in order; every count=2.
// - Backpressure: out_ready=0, send beats A(sel1) then B(sel3)
//   -> FULL, in_ready=0; A held stable; raising out_ready[1] delivers A,
//      then B next cycle.
// - Non-selected ready: head beat sel=0, out_ready=4'b1110
//   -> no transfer; counts unchanged; out_valid=4'b0001 held.
// - Counter wrap: CNT_WIDTH=8, 256 beats to port 3 -> count[3]=0; 257th -> 1.
// - Reset while FULL
//   -> next cycle out_valid=0, in_ready=1, counts=0; the two buffered beats
//      never appear.

Source files
------------

// File: rtl/demultiplexer4.sv
// Registered 1-to-4 stream demultiplexer with a skid buffer and per-port beat counters.
// A single beat stream is steered to one of four consumers by a 2-bit tag carried with each beat.
module demultiplexer4 #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [4*CNT_WIDTH-1:0] count
);

  logic             m_valid_q, m_valid_d;
  logic [1:0]       m_sel_q,   m_sel_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;
  logic             s_valid_q, s_valid_d;
  logic [1:0]       s_sel_q,   s_sel_d;
  logic [WIDTH-1:0] s_data_q,  s_data_d;

  logic in_fire;
  logic out_fire;

  // in_ready comes straight from the skid flop, so upstream never sees a path from out_ready.
  assign in_ready = !s_valid_q;
  assign in_fire  = in_valid && !s_valid_q;
  assign out_fire = m_valid_q && out_ready[m_sel_q];
  assign out_data = m_data_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_sel_d   = m_sel_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_sel_d   = s_sel_q;
    s_data_d  = s_data_q;
    case ({m_valid_q, s_valid_q})
      2'b00: begin
        if (in_fire) begin
          m_valid_d = 1'b1;
          m_sel_d   = in_sel;
          m_data_d  = in_data;
        end
      end
      2'b10: begin
        if (in_fire && out_fire) begin
          m_sel_d  = in_sel;
          m_data_d = in_data;
        end else if (in_fire) begin
          s_valid_d = 1'b1;
          s_sel_d   = in_sel;
          s_data_d  = in_data;
        end else if (out_fire) begin
          m_valid_d = 1'b0;
        end
      end
      2'b11: begin
        if (out_fire) begin
          m_sel_d   = s_sel_q;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
        end
      end
      2'b01: begin
        // Unreachable: the skid is only loaded while main holds a beat.
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_sel_q   <= 2'd0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_sel_q   <= 2'd0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_sel_q   <= m_sel_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_sel_q   <= s_sel_d;
      s_data_q  <= s_data_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port
      logic [CNT_WIDTH-1:0] cnt_q;
      logic [CNT_WIDTH-1:0] cnt_d;

      assign out_valid[gi] = m_valid_q && (m_sel_q == 2'(gi));
      assign cnt_d = (out_fire && (m_sel_q == 2'(gi))) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
      assign count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;

      always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end
  endgenerate

  a_no_skid_without_main : assert property (@(posedge clock) disable iff (reset)
    !(s_valid_q && !m_valid_q));

endmodule

// File: tb/tb_demultiplexer4.sv
// Randomized and directed bench for demultiplexer4; a FIFO-of-beats reference model feeds a
// scoreboard that a separate negedge monitor checks against the DUT outputs.
module tb_demultiplexer4;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 8;

  logic                   clock;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_sel;
  logic [WIDTH-1:0]       in_data;
  logic [3:0]             out_valid;
  logic [3:0]             out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [4*CNT_WIDTH-1:0] count;

  demultiplexer4 #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  // Reference model: the block is a two-deep ordered buffer of beats.
  beat_t sb[$];
  int    exp_cnt[4];
  bit    armed    = 1'b0;
  bit    acc_pend = 1'b0;
  bit    pop_pend = 1'b0;
  int    checks   = 0;
  int    errors   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model update on the active edge, using decisions made at the preceding negedge.
  always @(posedge clock) begin
    if (reset) begin
      sb.delete();
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
      armed = 1'b1;
    end else begin
      if (pop_pend) begin
        exp_cnt[sb[0].sel] = (exp_cnt[sb[0].sel] + 1) % (1 << CNT_WIDTH);
        void'(sb.pop_front());
      end
      if (acc_pend) sb.push_back('{sel: in_sel, data: in_data});
    end
  end

  // Acceptance side: a beat is taken whenever fewer than two beats are buffered.
  always @(negedge clock) begin
    acc_pend = armed && in_valid && (sb.size() < 2);
  end

  // Monitor: compare what the DUT presents against the head of the scoreboard.
  always @(negedge clock) begin
    logic [3:0] exp_ov;
    if (armed) begin
      exp_ov = 4'b0000;
      if (sb.size() > 0) exp_ov[sb[0].sel] = 1'b1;
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (sb.size() > 0) chk("out_data", 64'(out_data), 64'(sb[0].data));
      chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
      for (int i = 0; i < 4; i++)
        chk($sformatf("count[%0d]", i), 64'(count[i*CNT_WIDTH +: CNT_WIDTH]), 64'(exp_cnt[i]));
      pop_pend = (sb.size() > 0) && out_ready[sb[0].sel];
    end else begin
      pop_pend = 1'b0;
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] r);
    for (int k = 0; k < n; k++) drive(1'b0, 2'd0, '0, r);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 32'h1234_5678;
    out_ready = 4'b1111;
    @(posedge clock);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single beat to port 2.
    drive(1'b1, 2'd2, 32'hDEAD_BEEF, 4'b1111);
    idle(3, 4'b1111);

    // Streaming: eight back-to-back beats.
    for (int k = 0; k < 8; k++) drive(1'b1, 2'(k % 4), $urandom, 4'b1111);
    idle(3, 4'b1111);

    // Backpressure: A to port 1, B to port 3, then release port 1 then port 3.
    drive(1'b1, 2'd1, 32'hAAAA_0001, 4'b0000);
    drive(1'b1, 2'd3, 32'hBBBB_0003, 4'b0000);
    drive(1'b1, 2'd0, 32'hCCCC_0000, 4'b0000);
    idle(2, 4'b0000);
    idle(1, 4'b0010);
    idle(1, 4'b1000);
    idle(2, 4'b1111);

    // Head beat to port 0 while only the other ports are ready.
    drive(1'b1, 2'd0, 32'h0000_C0DE, 4'b1110);
    idle(4, 4'b1110);
    idle(2, 4'b1111);

    // Counter wrap on port 3.
    for (int k = 0; k < 257; k++) drive(1'b1, 2'd3, 32'(k), 4'b1111);
    idle(3, 4'b1111);

    // Reset while full: both buffered beats must vanish.
    drive(1'b1, 2'd0, 32'h5555_0000, 4'b0000);
    drive(1'b1, 2'd2, 32'h5555_0002, 4'b0000);
    reset = 1'b1;
    drive(1'b1, 2'd1, 32'h5555_0001, 4'b1111);
    reset = 1'b0;
    idle(3, 4'b1111);

    // Random traffic with one mid-run reset.
    for (int k = 0; k < 500; k++) begin
      reset = (k == 250);
      drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), $urandom,
            {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
    end
    reset = 1'b0;

    idle(10, 4'b1111);
    @(negedge clock);
    chk("drain empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
